// File: rtl/csr_access_unit.sv
// Controller side of the 6-entry machine CSR file: decodes CSR ops / ECALL / MRET,
// sequences per-entry writes over 1-2 cycles and returns old value plus PC redirect.
module csr_access_unit #(
  parameter int              XLEN        = 32,
  parameter int              NCSR        = 6,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 32'd11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_op,
  input  logic [11:0]               req_addr,
  input  logic [XLEN-1:0]           req_src,
  input  logic [XLEN-1:0]           req_pc,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      resp_illegal,
  output logic                      resp_redirect,
  output logic [XLEN-1:0]           resp_pc,
  input  logic [NCSR-1:0][XLEN-1:0] csr_rdata,
  output logic [NCSR-1:0][XLEN-1:0] csr_wdata,
  output logic [NCSR-1:0]           csr_wen
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_TRAP_MS = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  logic [1:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] src_q, src_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_illegal_q, resp_illegal_d;
  logic            resp_redirect_q, resp_redirect_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  logic [2:0]      idx;
  logic            addr_ok;
  logic [XLEN-1:0] old_val, new_val, ms_trap, ms_mret;

  always_comb begin
    idx     = 3'd0;
    addr_ok = 1'b1;
    case (addr_q)
      12'h300: idx = 3'd0;
      12'h341: idx = 3'd1;
      12'h342: idx = 3'd2;
      12'h340: idx = 3'd3;
      12'h343: idx = 3'd4;
      12'h305: idx = 3'd5;
      default: addr_ok = 1'b0;
    endcase
  end

  // mstatus update for trap entry and trap return; unrelated bits pass through
  always_comb begin
    ms_trap        = csr_rdata[0];
    ms_trap[7]     = csr_rdata[0][3];
    ms_trap[3]     = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_mret        = csr_rdata[0];
    ms_mret[3]     = csr_rdata[0][7];
    ms_mret[7]     = 1'b1;
    ms_mret[12:11] = 2'b11;
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    src_d           = src_q;
    pc_d            = pc_q;
    resp_rdata_d    = resp_rdata_q;
    resp_illegal_d  = resp_illegal_q;
    resp_redirect_d = resp_redirect_q;
    resp_pc_d       = resp_pc_q;
    csr_wen         = '0;
    csr_wdata       = '0;
    old_val         = csr_rdata[idx];
    new_val         = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d            = req_op;
          addr_d          = req_addr;
          src_d           = req_src;
          pc_d            = req_pc;
          resp_rdata_d    = '0;
          resp_illegal_d  = 1'b0;
          resp_redirect_d = 1'b0;
          resp_pc_d       = '0;
          state_d         = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        case (op_q)
          OP_RW, OP_RS, OP_RC: begin
            if (!addr_ok) begin
              resp_illegal_d = 1'b1;
            end else begin
              resp_rdata_d = old_val;
              if (op_q == OP_RW)      new_val = src_q;
              else if (op_q == OP_RS) new_val = old_val | src_q;
              else                    new_val = old_val & ~src_q;
              if (op_q == OP_RW || src_q != '0) begin
                csr_wen[idx]   = 1'b1;
                csr_wdata[idx] = new_val;
                // mstatus is mirrored onto lane 1 for the CSR file
                if (idx == 3'd0) csr_wdata[1] = new_val;
              end
            end
          end
          OP_ECALL: begin
            csr_wen[1]   = 1'b1;
            csr_wdata[1] = pc_q;
            csr_wen[2]   = 1'b1;
            csr_wdata[2] = ECALL_CAUSE;
            state_d      = S_TRAP_MS;
          end
          OP_MRET: begin
            csr_wen[0]      = 1'b1;
            csr_wdata[0]    = ms_mret;
            csr_wdata[1]    = ms_mret;
            resp_redirect_d = 1'b1;
            resp_pc_d       = csr_rdata[1];
          end
          default: resp_illegal_d = 1'b1;
        endcase
      end
      S_TRAP_MS: begin
        csr_wen[0]      = 1'b1;
        csr_wdata[0]    = ms_trap;
        csr_wdata[1]    = ms_trap;
        resp_redirect_d = 1'b1;
        resp_pc_d       = csr_rdata[5] & {{(XLEN-2){1'b1}}, 2'b00};
        state_d         = S_RESP;
      end
      default: begin
        if (resp_ready) state_d = S_IDLE;
      end
    endcase
    // an interrupted ECALL must not finish its mstatus write
    if (rst) begin
      csr_wen   = '0;
      csr_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      op_q            <= '0;
      addr_q          <= '0;
      src_q           <= '0;
      pc_q            <= '0;
      resp_rdata_q    <= '0;
      resp_illegal_q  <= 1'b0;
      resp_redirect_q <= 1'b0;
      resp_pc_q       <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      src_q           <= src_d;
      pc_q            <= pc_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_illegal_q  <= resp_illegal_d;
      resp_redirect_q <= resp_redirect_d;
      resp_pc_q       <= resp_pc_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_illegal  = resp_illegal_q;
  assign resp_redirect = resp_redirect_q;
  assign resp_pc       = resp_pc_q;

endmodule
